cnt_seq_checker: RTL and testbench

CNT_SEQ_CHECKER -- requirements
Module: cnt_seq_checker

---
 rtl/cnt_seq_checker.sv | 148 ++++++++++++++
 tb/tb_cnt_seq_checker.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cnt_seq_checker.sv
// Checks that a 2-bit up-counter steps by +1 mod 4, counts wraps and errors.
// Latency: 1 clk from an en=1 sample to the registered outputs.
// No backpressure: samples are taken whenever en=1. clr and rst have priority.
// Optional macro CNT_SEQ_RESYNC_EN: leave ERROR after 4 consecutive matches.
module cnt_seq_checker #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        cnt_in,
  input  logic              clr,
  output logic [1:0]        state,
  output logic [1:0]        exp_out,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRACK = 2'b01,
    ST_ERROR = 2'b10,
    ST_ILL   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        exp_q, exp_d;
  logic [1:0]        prev_q, prev_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
`ifdef CNT_SEQ_RESYNC_EN
  logic [1:0]        match_cnt_q, match_cnt_d;
`endif

  logic              match;
  assign match = (cnt_in == exp_q);

  // Next-state and output computation; everything holds unless a sample or clear acts.
  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    prev_d       = prev_q;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
`ifdef CNT_SEQ_RESYNC_EN
    match_cnt_d  = match_cnt_q;
`endif
    if (clr) begin
      state_d    = ST_IDLE;
      exp_d      = 2'd0;
      prev_d     = 2'd0;
      wrap_cnt_d = '0;
      err_d      = 1'b0;
      err_cnt_d  = '0;
`ifdef CNT_SEQ_RESYNC_EN
      match_cnt_d = 2'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First sample only seeds the tracker; nothing is checked yet.
          if (en) begin
            prev_d  = cnt_in;
            exp_d   = cnt_in + 2'd1;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK, ST_ERROR: begin
          if (en) begin
            // Match or not, the tracker always follows the observed value.
            prev_d = cnt_in;
            exp_d  = cnt_in + 2'd1;
            if (match) begin
              if (prev_q == 2'd3 && cnt_in == 2'd0) begin
                wrap_pulse_d = 1'b1;
                if (!(&wrap_cnt_q)) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
              end
`ifdef CNT_SEQ_RESYNC_EN
              if (state_q == ST_ERROR) begin
                if (match_cnt_q == 2'd3) begin
                  state_d     = ST_TRACK;
                  err_d       = 1'b0;
                  match_cnt_d = 2'd0;
                end else begin
                  match_cnt_d = match_cnt_q + 2'd1;
                end
              end
`endif
            end else begin
              err_d   = 1'b1;
              state_d = ST_ERROR;
              if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_W'(1);
`ifdef CNT_SEQ_RESYNC_EN
              match_cnt_d = 2'd0;
`endif
            end
          end
        end
        default: begin
          // Unreachable encoding: fall back to IDLE and reacquire.
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      exp_q        <= 2'd0;
      prev_q       <= 2'd0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
`ifdef CNT_SEQ_RESYNC_EN
      match_cnt_q  <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      prev_q       <= prev_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
`ifdef CNT_SEQ_RESYNC_EN
      match_cnt_q  <= match_cnt_d;
`endif
    end
  end

  assign state      = state_q;
  assign exp_out    = exp_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Scoreboard bench for cnt_seq_checker: directed vectors push expected outputs,
// a monitor pops one entry per clock edge and compares. A second instance with
// 2-bit counters shares the stimulus to exercise saturation.
module tb_cnt_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] cnt_in = 2'd0;

  logic [1:0] state, exp_out, state2, exp_out2;
  logic       wrap_pulse, err, wrap_pulse2, err2;
  logic [7:0] wrap_cnt, err_cnt;
  logic [1:0] wrap_cnt2, err_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] ex;
    logic       wp;
    logic [7:0] wc;
    logic       er;
    logic [7:0] ec;
  } exp_t;

  exp_t sb_q[$];

`ifdef CNT_SEQ_RESYNC_EN
  localparam logic [1:0] ST_REC = 2'd1;
  localparam logic       ER_REC = 1'b0;
`else
  localparam logic [1:0] ST_REC = 2'd2;
  localparam logic       ER_REC = 1'b1;
`endif

  cnt_seq_checker #(.WRAP_W(8), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr(clr),
    .state(state), .exp_out(exp_out), .wrap_pulse(wrap_pulse),
    .wrap_cnt(wrap_cnt), .err(err), .err_cnt(err_cnt)
  );

  cnt_seq_checker #(.WRAP_W(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_in), .clr(clr),
    .state(state2), .exp_out(exp_out2), .wrap_pulse(wrap_pulse2),
    .wrap_cnt(wrap_cnt2), .err(err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic v(input logic r, input logic c, input logic e, input logic [1:0] ci,
                   input logic [1:0] st, input logic [1:0] ex, input logic wp,
                   input int wc, input logic er, input int ec);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; en = e; cnt_in = ci;
    x.st = st; x.ex = ex; x.wp = wp; x.wc = 8'(wc); x.er = er; x.ec = 8'(ec);
    sb_q.push_back(x);
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("state",       int'(state),      int'(x.st));
        chk("exp_out",     int'(exp_out),    int'(x.ex));
        chk("wrap_pulse",  int'(wrap_pulse), int'(x.wp));
        chk("wrap_cnt",    int'(wrap_cnt),   int'(x.wc));
        chk("err",         int'(err),        int'(x.er));
        chk("err_cnt",     int'(err_cnt),    int'(x.ec));
        chk("w2_state",    int'(state2),     int'(x.st));
        chk("w2_wrap_pulse", int'(wrap_pulse2), int'(x.wp));
        chk("w2_wrap_cnt", int'(wrap_cnt2),  (x.wc > 8'd3) ? 3 : int'(x.wc));
        chk("w2_err_cnt",  int'(err_cnt2),   (x.ec > 8'd3) ? 3 : int'(x.ec));
      end
    end
  end

  initial begin
    // Reset, then a legal 0,1,2,3,0,1 run with one wrap.
    v(1,0,0,0, 0,0,0,0,0,0);
    v(1,0,0,0, 0,0,0,0,0,0);
    v(0,0,1,0, 1,1,0,0,0,0);
    v(0,0,1,1, 1,2,0,0,0,0);
    v(0,0,1,2, 1,3,0,0,0,0);
    v(0,0,1,3, 1,0,0,0,0,0);
    v(0,0,1,0, 1,1,1,1,0,0);
    v(0,0,1,1, 1,2,0,1,0,0);
    // en=0 holds everything.
    v(0,0,0,3, 1,2,0,1,0,0);
    // Mismatch 0 against expected 2: enter ERROR, resync, no wrap.
    v(0,0,1,0, 2,1,0,1,1,1);
    // Four matches in ERROR ending in a wrap.
    v(0,0,1,1, 2,2,0,1,1,1);
    v(0,0,1,2, 2,3,0,1,1,1);
    v(0,0,1,3, 2,0,0,1,1,1);
    v(0,0,1,0, ST_REC,1,1,2,ER_REC,1);
    // Two mismatches, then matches with wraps up past 2-bit saturation.
    v(0,0,1,3, 2,0,0,2,1,2);
    v(0,0,1,2, 2,3,0,2,1,3);
    v(0,0,1,3, 2,0,0,2,1,3);
    v(0,0,1,0, 2,1,1,3,1,3);
    v(0,0,1,1, 2,2,0,3,1,3);
    v(0,0,1,2, ST_REC,3,0,3,ER_REC,3);
    v(0,0,1,3, ST_REC,0,0,3,ER_REC,3);
    v(0,0,1,0, ST_REC,1,1,4,ER_REC,3);
    v(0,0,1,1, ST_REC,2,0,4,ER_REC,3);
    v(0,0,1,2, ST_REC,3,0,4,ER_REC,3);
    v(0,0,1,3, ST_REC,0,0,4,ER_REC,3);
    v(0,0,1,0, ST_REC,1,1,5,ER_REC,3);
    // Fourth error: 2-bit error counter stays saturated.
    v(0,0,1,3, 2,0,0,5,1,4);
    // clr with a mismatching same-cycle sample.
    v(0,1,1,2, 0,0,0,0,0,0);
    v(0,0,0,1, 0,0,0,0,0,0);
    // en toggling through a legal sequence.
    v(0,0,1,2, 1,3,0,0,0,0);
    v(0,0,0,1, 1,3,0,0,0,0);
    v(0,0,1,3, 1,0,0,0,0,0);
    v(0,0,0,2, 1,0,0,0,0,0);
    v(0,0,1,0, 1,1,1,1,0,0);
    v(0,0,0,0, 1,1,0,1,0,0);
    v(0,0,1,1, 1,2,0,1,0,0);
    // rst mid-sequence beats a mismatching sample.
    v(1,0,1,0, 0,0,0,0,0,0);
    // First sample after release is an IDLE capture.
    v(0,0,1,3, 1,0,0,0,0,0);
    v(0,0,1,1, 2,2,0,0,1,1);
    // rst in ERROR beats clr and en.
    v(1,1,1,2, 0,0,0,0,0,0);
    v(0,0,0,0, 0,0,0,0,0,0);
    repeat (3) @(negedge clk);
    chk("queue_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
